// File: rtl/friscv_rv32i_sequencer.sv
// friscv_rv32i_sequencer: in-order RV32I control-flow sequencer.
// Fetches one instruction at a time and resolves JAL, JALR, BRANCH, AUIPC
// and FENCE locally. LUI, LOAD, STORE, OP-IMM, OP and SYSTEM are dispatched
// to a processing unit. Any other opcode parks the sequencer in TRAP.
//
// Build macro FRISCV_MISALIGN_CHECK_EN: when defined, a jump or taken-branch
// target whose bits[1:0] are not zero traps, with no rd write and the PC left
// on the faulting instruction. When undefined, target bit1 is cleared and
// execution continues.
//
// Handshakes: fetch_* and proc_* are valid/ready channels. A transfer happens
// on a rising aclk edge where valid and ready are both high. Once valid is
// raised, it and its payload hold until that transfer. fetch_rvalid has no
// ready: it is consumed only in WAIT and ignored in every other state.
module friscv_rv32i_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            aclk,
  input  logic            arst,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_rvalid,
  input  logic [31:0]     fetch_rdata,
  output logic            proc_valid,
  input  logic            proc_ready,
  output logic [31:0]     proc_instr,
  output logic [XLEN-1:0] proc_pc,
  input  logic            proc_busy,
  output logic [4:0]      rs1_addr,
  input  logic [XLEN-1:0] rs1_val,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs2_val,
  output logic            rd_wr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_val,
  output logic [XLEN-1:0] pc,
  output logic            ctrl_error,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    WAIT     = 3'd1,
    EXEC     = 3'd2,
    DISPATCH = 3'd3,
    TRAP     = 3'd4
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            err_q, err_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            rd_nz;
  logic [XLEN-1:0] imm_i, imm_j, imm_b, imm_u, pc_seq;
  logic            br_taken, br_illegal;
  logic [XLEN-1:0] target_raw, target;
  logic            misaligned;

  // Field extraction and sign-extended immediates from the instruction register.
  always_comb begin
    opcode = instr_q[6:0];
    funct3 = instr_q[14:12];
    rd_nz  = (instr_q[11:7] != 5'd0);
    imm_i  = XLEN'($signed(instr_q[31:20]));
    imm_j  = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));
    imm_b  = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
    imm_u  = XLEN'($signed({instr_q[31:12], 12'b0}));
    pc_seq = pc_q + XLEN'(4);
  end

  // Branch condition evaluation. funct3 010/011 has no branch meaning.
  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_illegal = 1'b1;
    endcase
  end

  // Redirect target. All sums wrap modulo 2^XLEN. rs1_val is the value read
  // this cycle, so a JALR with rd == rs1 uses the pre-write register.
  always_comb begin
    case (opcode)
      OP_JALR:   target_raw = (rs1_val + imm_i) & ~XLEN'(1);
      OP_BRANCH: target_raw = pc_q + imm_b;
      default:   target_raw = pc_q + imm_j;
    endcase
  end

`ifdef FRISCV_MISALIGN_CHECK_EN
  assign misaligned = (target_raw[1:0] != 2'b00);
  assign target     = target_raw;
`else
  assign misaligned = 1'b0;
  assign target     = target_raw & ~XLEN'(2);
`endif

  // Next-state, PC update and handshake/strobe outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    err_d       = err_q;
    fetch_valid = 1'b0;
    proc_valid  = 1'b0;
    rd_wr       = 1'b0;
    rd_val      = pc_seq;
    case (state_q)
      FETCH: begin
        fetch_valid = 1'b1;
        if (fetch_ready) state_d = WAIT;
      end
      WAIT: begin
        if (fetch_rvalid) begin
          instr_d = fetch_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (opcode)
          OP_LUI, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM: state_d = DISPATCH;
          OP_FENCE: begin
            pc_d    = pc_seq;
            state_d = FETCH;
          end
          OP_AUIPC: begin
            if (!proc_busy) begin
              rd_wr   = rd_nz;
              rd_val  = pc_q + imm_u;
              pc_d    = pc_seq;
              state_d = FETCH;
            end
          end
          OP_JAL, OP_JALR: begin
            if (!proc_busy) begin
              if (misaligned) begin
                state_d = TRAP;
                err_d   = 1'b1;
              end else begin
                rd_wr   = rd_nz;
                pc_d    = target;
                state_d = FETCH;
              end
            end
          end
          OP_BRANCH: begin
            if (!proc_busy) begin
              if (br_illegal || (br_taken && misaligned)) begin
                state_d = TRAP;
                err_d   = 1'b1;
              end else begin
                pc_d    = br_taken ? target : pc_seq;
                state_d = FETCH;
              end
            end
          end
          default: begin
            state_d = TRAP;
            err_d   = 1'b1;
          end
        endcase
      end
      DISPATCH: begin
        proc_valid = 1'b1;
        if (proc_ready) begin
          pc_d    = pc_seq;
          state_d = FETCH;
        end
      end
      TRAP: state_d = TRAP;
      default: begin
        state_d = TRAP;
        err_d   = 1'b1;
      end
    endcase
  end

  // State registers; arst abandons any in-flight transfer.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= FETCH;
      pc_q    <= BOOT_ADDR;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign fetch_addr = pc_q;
  assign proc_instr = instr_q;
  assign proc_pc    = pc_q;
  assign rs1_addr   = instr_q[19:15];
  assign rs2_addr   = instr_q[24:20];
  assign rd_addr    = instr_q[11:7];
  assign pc         = pc_q;
  assign ctrl_error = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_friscv_rv32i_sequencer.sv
// Testbench for friscv_rv32i_sequencer (BOOT_ADDR = 0x100).
module tb_friscv_rv32i_sequencer;

  localparam logic [31:0] BOOT = 32'h100;
  localparam int          W    = 66;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_PROC  = 2'd1;
  localparam logic [1:0] K_RD    = 2'd2;

  localparam logic [31:0] ST_FETCH = 32'd0;
  localparam logic [31:0] ST_WAIT  = 32'd1;
  localparam logic [31:0] ST_EXEC  = 32'd2;
  localparam logic [31:0] ST_DISP  = 32'd3;
  localparam logic [31:0] ST_TRAP  = 32'd4;

  localparam logic [31:0] I_ADDI      = 32'h00100093;
  localparam logic [31:0] I_JAL_200   = 32'h0FC0006F;
  localparam logic [31:0] I_JAL_X1    = 32'h008000EF;
  localparam logic [31:0] I_JAL_300   = 32'h0F80006F;
  localparam logic [31:0] I_BEQ       = 32'h00208863;
  localparam logic [31:0] I_BLT       = 32'h0020C863;
  localparam logic [31:0] I_BLTU      = 32'h0020E863;
  localparam logic [31:0] I_AUIPC     = 32'h00001197;
  localparam logic [31:0] I_FENCE     = 32'h0000000F;
  localparam logic [31:0] I_LUI       = 32'h123452B7;
  localparam logic [31:0] I_JAL_400   = 32'h0CC0006F;
  localparam logic [31:0] I_JALR      = 32'h00228067;
  localparam logic [31:0] I_JALR_WRAP = 32'h008280E7;
  localparam logic [31:0] I_ILL       = 32'hFFFFFFFF;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic        fetch_valid, fetch_ready, fetch_rvalid;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        proc_valid, proc_ready, proc_busy;
  logic [31:0] proc_instr, proc_pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_val, rs2_val, rd_val, pc;
  logic        rd_wr, ctrl_error;
  logic [2:0]  state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  ill_addr;

  friscv_rv32i_sequencer #(.XLEN(32), .BOOT_ADDR(BOOT)) dut (
    .aclk(aclk), .arst(arst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .proc_valid(proc_valid), .proc_ready(proc_ready), .proc_instr(proc_instr), .proc_pc(proc_pc),
    .proc_busy(proc_busy),
    .rs1_addr(rs1_addr), .rs1_val(rs1_val), .rs2_addr(rs2_addr), .rs2_val(rs2_val),
    .rd_wr(rd_wr), .rd_addr(rd_addr), .rd_val(rd_val),
    .pc(pc), .ctrl_error(ctrl_error), .state_dbg(state_dbg)
  );

  // Clock
  always #5 aclk = ~aclk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input logic [1:0] kind,
                       input logic [31:0] a, input logic [31:0] b);
    logic [W-1:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: unexpected event a=%08h b=%08h, none expected", name, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, a, b}) begin
        tests_failed++;
        $display("FAIL %s: got kind=%0d a=%08h b=%08h expected kind=%0d a=%08h b=%08h",
                 name, kind, a, b, e[65:64], e[63:32], e[31:0]);
      end
    end
  endtask

  // Monitor: every transfer or write strobe is matched against the queue.
  always @(negedge aclk) begin
    if (!arst) begin
      if (fetch_valid && fetch_ready) score("fetch", K_FETCH, fetch_addr, 32'h0);
      if (proc_valid && proc_ready)   score("dispatch", K_PROC, proc_pc, proc_instr);
      if (rd_wr)                      score("rd_write", K_RD, {27'h0, rd_addr}, rd_val);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic fetch_hs(input logic [31:0] addr);
    bit hs;
    int n;
    exp_q.push_back({K_FETCH, addr, 32'h0});
    fetch_ready = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge aclk);
      hs = fetch_valid;
      tick();
      n++;
    end
    fetch_ready = 1'b0;
    if (!hs) begin
      tests_run++;
      tests_failed++;
      $display("FAIL fetch_timeout: no fetch_valid in 50 cycles, expected addr %08h", addr);
    end
  endtask

  task automatic respond(input logic [31:0] instr);
    fetch_rdata  = instr;
    fetch_rvalid = 1'b1;
    tick();
    fetch_rvalid = 1'b0;
    fetch_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    check("reset_async_state", 32'(state_dbg), ST_FETCH);
    check("reset_async_pc", pc, BOOT);
    repeat (2) @(posedge aclk);
    #1;
    arst = 1'b0;
    @(negedge aclk);
    check("reset_fetch_valid", 32'(fetch_valid), 32'd1);
    check("reset_fetch_addr", fetch_addr, BOOT);
    check("reset_ctrl_error", 32'(ctrl_error), 32'd0);
    check("reset_proc_valid", 32'(proc_valid), 32'd0);
    check("reset_rd_wr", 32'(rd_wr), 32'd0);
    tick();
  endtask

  initial begin
    fetch_ready  = 1'b0;
    fetch_rvalid = 1'b0;
    fetch_rdata  = 32'h0;
    proc_ready   = 1'b1;
    proc_busy    = 1'b0;
    rs1_val      = 32'h0;
    rs2_val      = 32'h0;
    tick();
    do_reset();

    // ADDI dispatched at boot address, then sequential fetch
    fetch_hs(32'h100);
    exp_q.push_back({K_PROC, 32'h100, I_ADDI});
    respond(I_ADDI);
    fetch_hs(32'h104);
    respond(I_JAL_200);

    // JAL x1, +8 at 0x200
    fetch_hs(32'h200);
    exp_q.push_back({K_RD, 32'd1, 32'h204});
    respond(I_JAL_X1);
    fetch_hs(32'h208);
    respond(I_JAL_300);

    // BEQ taken, held in EXEC while proc_busy is high
    fetch_hs(32'h300);
    rs1_val   = 32'd5;
    rs2_val   = 32'd5;
    proc_busy = 1'b1;
    respond(I_BEQ);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("busy_hold_state", 32'(state_dbg), ST_EXEC);
      check("busy_no_fetch", 32'(fetch_valid), 32'd0);
      tick();
    end
    check("beq_rs1_addr", 32'(rs1_addr), 32'd1);
    check("beq_rs2_addr", 32'(rs2_addr), 32'd2);
    proc_busy = 1'b0;
    fetch_hs(32'h310);

    // BEQ not taken
    rs2_val = 32'd6;
    respond(I_BEQ);
    fetch_hs(32'h314);

    // BLT signed taken, BLTU unsigned not taken
    rs1_val = 32'hFFFFFFFF;
    rs2_val = 32'd1;
    respond(I_BLT);
    fetch_hs(32'h324);
    respond(I_BLTU);

    // AUIPC x3, 0x1
    fetch_hs(32'h328);
    exp_q.push_back({K_RD, 32'd3, 32'h1328});
    respond(I_AUIPC);

    // FENCE is a NOP
    fetch_hs(32'h32C);
    respond(I_FENCE);

    // LUI with proc_ready held low for 4 DISPATCH cycles
    fetch_hs(32'h330);
    proc_ready = 1'b0;
    respond(I_LUI);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("disp_hold_valid", 32'(proc_valid), 32'd1);
      check("disp_hold_instr", proc_instr, I_LUI);
      check("disp_hold_pc", proc_pc, 32'h330);
      check("disp_no_fetch", 32'(fetch_valid), 32'd0);
      tick();
    end
    exp_q.push_back({K_PROC, 32'h330, I_LUI});
    proc_ready = 1'b1;
    fetch_hs(32'h334);
    respond(I_JAL_400);

    // JALR x0, 2(x5) with x5 = 0x100 -> target 0x102
    fetch_hs(32'h400);
    rs1_val = 32'h100;
    respond(I_JALR);
    @(negedge aclk);
    check("jalr_rs1_addr", 32'(rs1_addr), 32'd5);
    tick();
`ifdef FRISCV_MISALIGN_CHECK_EN
    @(negedge aclk);
    check("jalr_misalign_state", 32'(state_dbg), ST_TRAP);
    check("jalr_misalign_err", 32'(ctrl_error), 32'd1);
    check("jalr_misalign_pc", pc, 32'h400);
    tick();
    do_reset();
    ill_addr = 32'h100;
`else
    // JALR x1, 8(x5) with x5 = 0xFFFFFFFC wraps to 0x4
    fetch_hs(32'h100);
    exp_q.push_back({K_RD, 32'd1, 32'h104});
    rs1_val = 32'hFFFFFFFC;
    respond(I_JALR_WRAP);
    ill_addr = 32'h4;
`endif

    // Illegal instruction traps; fetch and responses ignored while trapped
    fetch_hs(ill_addr);
    respond(I_ILL);
    tick();
    fetch_ready  = 1'b1;
    fetch_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("trap_state", 32'(state_dbg), ST_TRAP);
      check("trap_ctrl_error", 32'(ctrl_error), 32'd1);
      check("trap_pc", pc, ill_addr);
      check("trap_fetch_valid", 32'(fetch_valid), 32'd0);
      check("trap_proc_valid", 32'(proc_valid), 32'd0);
      tick();
    end
    fetch_ready  = 1'b0;
    fetch_rvalid = 1'b0;
    do_reset();

    // Stray response outside WAIT is ignored
    fetch_rdata  = I_ILL;
    fetch_rvalid = 1'b1;
    tick();
    fetch_rvalid = 1'b0;
    @(negedge aclk);
    check("stray_rvalid_state", 32'(state_dbg), ST_FETCH);
    tick();

    // Reset while waiting for a response abandons it
    fetch_hs(32'h100);
    exp_q.push_back({K_PROC, 32'h100, I_ADDI});
    respond(I_ADDI);
    fetch_hs(32'h104);
    check("pre_reset_wait", 32'(state_dbg), ST_WAIT);
    arst = 1'b1;
    #1;
    check("midhs_reset_state", 32'(state_dbg), ST_FETCH);
    check("midhs_reset_pc", pc, BOOT);
    tick();
    arst = 1'b0;
    @(negedge aclk);
    check("midhs_resume_addr", fetch_addr, BOOT);
    check("midhs_resume_valid", 32'(fetch_valid), 32'd1);
    tick();
    fetch_hs(32'h100);
    exp_q.push_back({K_PROC, 32'h100, I_ADDI});
    respond(I_ADDI);
    fetch_hs(32'h104);
    check("final_wait_state", 32'(state_dbg), ST_WAIT);
    repeat (3) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/friscv_rv32i_sequencer.md
FRISCV_RV32I_SEQUENCER -- requirements
Module: friscv_rv32i_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter BOOT_ADDR, default 0, first fetch address after reset.
REQ-003 SHALL have port aclk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port arst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports fetch_valid out 1, fetch_ready in 1, fetch_addr out XLEN: instruction read request, transferred when valid&ready.
REQ-006 SHALL have ports fetch_rvalid in 1, fetch_rdata in 32: read response, always accepted.
REQ-007 SHALL have ports proc_valid out 1, proc_ready in 1, proc_instr out 32, proc_pc out XLEN: dispatch to processing unit.
REQ-008 SHALL have port proc_busy in 1, high while the processing unit holds uncommitted register writes.
REQ-009 SHALL have ports rs1_addr out 5, rs1_val in XLEN, rs2_addr out 5, rs2_val in XLEN: combinational register-file read.
REQ-010 SHALL have ports rd_wr out 1, rd_addr out 5, rd_val out XLEN: one-cycle register write strobe.
REQ-011 SHALL have ports pc out XLEN (current PC) and ctrl_error out 1 (sticky fault flag).

Function
REQ-012 SHALL implement states FETCH, WAIT, EXEC, DISPATCH, TRAP.
REQ-013 FETCH: fetch_valid=1, fetch_addr=pc; on handshake go to WAIT; fetch_valid SHALL stay high and fetch_addr stable until ready.
REQ-014 WAIT: on fetch_rvalid capture fetch_rdata into instruction register, go to EXEC; other cycles hold.
REQ-015 EXEC: decode opcode = instr[6:0]; rs1/rs2 fields drive rs1_addr/rs2_addr; if opcode in {JAL, JALR, BRANCH, AUIPC} and proc_busy=1, stay in EXEC.
REQ-016 LUI, LOAD, STORE, OP-IMM, OP, CSR (1110011) SHALL go to DISPATCH with proc_instr=instr, proc_pc=pc.
REQ-017 DISPATCH: proc_valid=1 with stable payload until proc_ready; on handshake pc+=4, go to FETCH.
REQ-018 JAL: rd_wr pulse with rd_val=pc+4 (suppressed if rd=0); pc+=sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); go to FETCH.
REQ-019 JALR: rd_wr with rd_val=pc+4 (rd!=0); pc=(rs1_val+sext(instr[31:20])) with bit0 cleared; rs1_val SHALL be sampled before the write.
REQ-020 BRANCH: imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE signed, 110 BLTU, 111 BGEU unsigned; taken: pc+=imm, else pc+=4; funct3 010/011 illegal.
REQ-021 AUIPC: rd_wr with rd_val=pc+{instr[31:12],12'b0} (rd!=0); pc+=4.
REQ-022 FENCE (0001111) SHALL act as NOP: pc+=4, no dispatch.
REQ-023 Any other opcode or illegal funct3 SHALL go to TRAP; pc unchanged (faulting address).
REQ-024 TRAP: all valid/wr outputs 0, ctrl_error=1, remain until arst.
REQ-025 All PC arithmetic SHALL be modulo 2^XLEN (wrap silently).
REQ-026 EXEC for JAL/JALR/BRANCH/AUIPC/FENCE SHALL take exactly one cycle; instruction-to-next-fetch_valid latency for these is 1 cycle.
REQ-027 At most one fetch SHALL be outstanding; fetch_rvalid outside WAIT SHALL be ignored.

Reset
REQ-028 arst SHALL immediately force state FETCH, pc=BOOT_ADDR, instruction register 0, ctrl_error=0, proc_valid=0, rd_wr=0; fetch_valid=1 in first cycle after release.
REQ-029 arst mid-handshake SHALL abandon the transaction; no replay afterwards.

Configuration
REQ-030 Macro FRISCV_MISALIGN_CHECK_EN defined: a JAL, JALR or taken-branch target with bits[1:0]!=0 SHALL go to TRAP with no rd write and pc unchanged.
REQ-031 Macro undefined: target bit1 SHALL be forced to 0 and execution continues; ctrl_error never set by alignment.

Verification
REQ-032 Release arst, BOOT_ADDR=0x100, fetch_ready=1 -> fetch_addr=0x100 first cycle; ADDI 0x00100093 -> proc_valid with proc_pc=0x100, then fetch 0x104.
REQ-033 pc=0x200, JAL 0x008000EF -> rd_wr, rd_addr=1, rd_val=0x204; next fetch_addr=0x208.
REQ-034 pc=0x300, BEQ 0x00208863 with rs1_val=rs2_val=5 -> next fetch 0x310; rs2_val=6 -> 0x304.
REQ-035 pc=0x400, JALR 0x00228067, rs1_val=0x100 -> with macro: TRAP, ctrl_error=1, pc=0x400; without: fetch 0x100.
REQ-036 Instruction 0xFFFFFFFF -> TRAP, no proc_valid, ctrl_error=1; arst pulse -> fetch resumes at BOOT_ADDR.
REQ-037 proc_busy=1 for 3 cycles during BRANCH, proc_ready low 4 cycles in DISPATCH -> EXEC/DISPATCH held, payload stable, no extra fetches.
